// File: rtl/fetch_sequencer.sv
// Instruction fetch stage: sequences ROM address/read strobes, assembles one- or two-byte
// instructions and hands them to the decoder over a valid/ready handshake.
module fetch_sequencer #(
    parameter logic [7:0] RESET_PC  = 8'd0,
    parameter logic [7:0] IMM_MASK  = 8'hE0,
    parameter logic [7:0] IMM_MATCH = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] rom_addr,
    output logic       rom_set_addr,
    output logic       rom_en_data,
    input  logic [7:0] rom_data,
    input  logic [7:0] rom_noi,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_opcode,
    output logic [7:0] instr_imm,
    output logic [7:0] instr_pc,
    output logic       instr_two_byte,
    input  logic       jump_en,
    input  logic [7:0] jump_addr,
    output logic       busy,
    output logic       halted
);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StSetOp,
        StReadOp,
        StSetImm,
        StReadImm,
        StIssue,
        StHalt
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] rom_addr_d;
    logic [7:0] opcode_d, imm_d, ipc_d;
    logic       two_d;
    logic [8:0] pc_inc;
    logic [8:0] pc_step;
    logic       is_two;

    assign pc_inc  = {1'b0, pc_q} + 9'd1;
    assign pc_step = {1'b0, pc_q} + (instr_two_byte ? 9'd2 : 9'd1);
    assign is_two  = (rom_data & IMM_MASK) == IMM_MATCH;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        opcode_d = instr_opcode;
        imm_d    = instr_imm;
        ipc_d    = instr_pc;
        two_d    = instr_two_byte;

        case (state_q)
            StIdle: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if ({1'b0, pc_q} >= {1'b0, rom_noi}) begin
                    state_d = StHalt;
                end else begin
                    state_d = StSetOp;
                end
            end
            StSetOp: state_d = StReadOp;
            StReadOp: begin
                opcode_d = rom_data;
                ipc_d    = pc_q;
                two_d    = is_two;
                imm_d    = 8'h00;
                // A two-byte opcode in the last ROM slot issues with a zero immediate.
                if (is_two && (pc_inc < {1'b0, rom_noi})) begin
                    state_d = StSetImm;
                end else begin
                    state_d = StIssue;
                end
            end
            StSetImm: state_d = StReadImm;
            StReadImm: begin
                imm_d   = rom_data;
                state_d = StIssue;
            end
            StIssue: begin
                if (instr_ready) begin
                    pc_d    = pc_step[7:0];
                    state_d = StCheck;
                end
            end
            StHalt: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = StCheck;
                end
            end
            default: state_d = StIdle;
        endcase

        // Redirect overrides every other transition, including an accepted issue.
        if (jump_en && (state_q != StIdle)) begin
            pc_d    = jump_addr;
            state_d = StCheck;
        end
    end

    always_comb begin
        rom_addr_d = rom_addr;
        if (state_d == StSetOp) begin
            rom_addr_d = pc_d;
        end else if (state_d == StSetImm) begin
            rom_addr_d = pc_inc[7:0];
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            pc_q           <= RESET_PC;
            rom_addr       <= 8'h00;
            rom_set_addr   <= 1'b0;
            rom_en_data    <= 1'b0;
            instr_valid    <= 1'b0;
            instr_opcode   <= 8'h00;
            instr_imm      <= 8'h00;
            instr_pc       <= 8'h00;
            instr_two_byte <= 1'b0;
            busy           <= 1'b0;
            halted         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            rom_addr       <= rom_addr_d;
            rom_set_addr   <= (state_d == StSetOp) || (state_d == StSetImm);
            rom_en_data    <= (state_d == StReadOp) || (state_d == StReadImm);
            instr_valid    <= (state_d == StIssue);
            instr_opcode   <= opcode_d;
            instr_imm      <= imm_d;
            instr_pc       <= ipc_d;
            instr_two_byte <= two_d;
            busy           <= (state_d != StIdle) && (state_d != StHalt);
            halted         <= (state_d == StHalt);
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: behavioural ROM, reference program walker feeding
// a scoreboard queue, and per-scenario directed tasks.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, rom_set_addr, rom_en_data, instr_valid, instr_ready;
    logic       instr_two_byte, jump_en, busy, halted;
    logic [7:0] rom_addr, rom_data, rom_noi, instr_opcode, instr_imm, instr_pc, jump_addr;

    logic [7:0] mem [256];
    logic [7:0] lat_addr;
    int pass_cnt  = 0;
    int total_cnt = 0;
    int excl_viol = 0;
    int en_count  = 0;
    int set_count = 0;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] imm;
        logic [7:0] pc;
        logic       two;
    } instr_t;

    instr_t exp_q[$];

    fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .rom_addr       (rom_addr),
        .rom_set_addr   (rom_set_addr),
        .rom_en_data    (rom_en_data),
        .rom_data       (rom_data),
        .rom_noi        (rom_noi),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_opcode   (instr_opcode),
        .instr_imm      (instr_imm),
        .instr_pc       (instr_pc),
        .instr_two_byte (instr_two_byte),
        .jump_en        (jump_en),
        .jump_addr      (jump_addr),
        .busy           (busy),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    // ROM latches the address on the set strobe and drives data while enabled.
    always @(posedge clk) if (rom_set_addr) lat_addr <= rom_addr;
    assign rom_data = rom_en_data ? mem[lat_addr] : 8'h00;

    always @(negedge clk) begin
        if (rom_set_addr && rom_en_data) excl_viol++;
        if (rom_en_data) en_count++;
        if (rom_set_addr) set_count++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; jump_en = 1'b0; jump_addr = 8'h00; instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Reference walk of the program from start_pc until the PC leaves the valid ROM range.
    task automatic push_model(input int start_pc);
        int pc = start_pc;
        instr_t e;
        for (int n = 0; n < 300 && pc < int'(rom_noi); n++) begin
            e.op  = mem[pc];
            e.pc  = pc[7:0];
            e.two = (mem[pc] & 8'hE0) == 8'h20;
            e.imm = (e.two && (pc + 1 < int'(rom_noi))) ? mem[pc + 1] : 8'h00;
            exp_q.push_back(e);
            pc = (pc + (e.two ? 2 : 1)) % 256;
        end
    endtask

    task automatic run_scoreboard(input int max_cycles, input string tag);
        int cyc = 0;
        int quiet_bad = 0;
        instr_t got, e;
        while (!halted && cyc < max_cycles) begin
            @(negedge clk);
            cyc++;
            if (instr_valid && instr_ready) begin
                got = {instr_opcode, instr_imm, instr_pc, instr_two_byte};
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL %s_unexpected_instr got=%h required=none", tag, got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) $display("FAIL %s_instr got=%h required=%h", tag, got, e);
                    else pass_cnt++;
                end
            end
        end
        total_cnt++;
        if (halted !== 1'b1) $display("FAIL %s_halt halted=%b required=1", tag, halted);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rom_set_addr || rom_en_data || instr_valid || busy || !halted) quiet_bad++;
        end
        total_cnt++;
        if (quiet_bad !== 0) $display("FAIL %s_quiet bad_cycles=%0d required=0", tag, quiet_bad);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() !== 0)
            $display("FAIL %s_pending left=%0d required=0", tag, exp_q.size());
        else pass_cnt++;
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [39:0] outs;
        do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        outs = {rom_addr, rom_set_addr, rom_en_data, instr_valid, instr_opcode, instr_imm,
                instr_pc, instr_two_byte, busy, halted};
        total_cnt++;
        if (outs !== '0) $display("FAIL reset_outputs got=%h required=0", outs);
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({busy, halted, rom_set_addr, instr_valid} !== 4'b0)
            $display("FAIL idle_no_start got=%b required=0000",
                     {busy, halted, rom_set_addr, instr_valid});
        else pass_cnt++;
    endtask

    task automatic test_load_imm();
        int e_set [6] = '{0, 1, 0, 1, 0, 0};
        int e_en  [6] = '{0, 0, 1, 0, 1, 0};
        int e_val [6] = '{0, 0, 0, 0, 0, 1};
        int e_adr [6] = '{0, 0, 0, 1, 1, 1};
        logic [10:0] got, req;
        do_reset();
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h01; rom_noi = 8'd22;
        pulse_start();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            got = {rom_set_addr, rom_en_data, instr_valid, rom_addr};
            req = {e_set[c][0], e_en[c][0], e_val[c][0], e_adr[c][7:0]};
            total_cnt++;
            if (got !== req) $display("FAIL load_imm_cycle%0d got=%h required=%h", c + 1, got, req);
            else pass_cnt++;
        end
        total_cnt++;
        if ({instr_opcode, instr_imm, instr_pc, instr_two_byte} !== {8'h20, 8'h01, 8'h00, 1'b1})
            $display("FAIL load_imm_fields got=%h_%h_%h_%b required=20_01_00_1",
                     instr_opcode, instr_imm, instr_pc, instr_two_byte);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if ({rom_set_addr, rom_addr} !== {1'b1, 8'h02})
            $display("FAIL load_imm_next_pc got=%b_%h required=1_02", rom_set_addr, rom_addr);
        else pass_cnt++;
    endtask

    task automatic test_full_program();
        logic [7:0] prog [22] = '{8'h20, 8'h01, 8'h21, 8'h00, 8'h22, 8'h00, 8'h23, 8'h09,
                                  8'h81, 8'h82, 8'h24, 8'h05, 8'h83, 8'h40, 8'h3F, 8'h11,
                                  8'h90, 8'h25, 8'h07, 8'hA0, 8'h01, 8'h26};
        do_reset();
        clear_mem();
        for (int i = 0; i < 22; i++) mem[i] = prog[i];
        rom_noi = 8'd22;
        push_model(0);
        pulse_start();
        run_scoreboard(400, "full_program");
    endtask

    task automatic test_backpressure();
        logic [26:0] snap, now;
        int cyc = 0;
        do_reset();
        clear_mem();
        mem[0] = 8'h81; mem[1] = 8'h82; rom_noi = 8'd22;
        instr_ready = 1'b0;
        pulse_start();
        while (!instr_valid && cyc < 20) begin @(negedge clk); cyc++; end
        snap = {instr_valid, rom_set_addr, rom_en_data, instr_opcode, instr_imm, instr_pc};
        total_cnt++;
        if (snap[26] !== 1'b1) $display("FAIL bp_valid got=%b required=1", snap[26]);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            now = {instr_valid, rom_set_addr, rom_en_data, instr_opcode, instr_imm, instr_pc};
            total_cnt++;
            if (now !== snap) $display("FAIL bp_hold%0d got=%h required=%h", i, now, snap);
            else pass_cnt++;
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        total_cnt++;
        if (instr_valid !== 1'b0) $display("FAIL bp_single_accept valid=%b required=0", instr_valid);
        else pass_cnt++;
        cyc = 0;
        while (!instr_valid && cyc < 20) begin @(negedge clk); cyc++; end
        total_cnt++;
        if ({instr_valid, instr_pc, instr_opcode} !== {1'b1, 8'h01, 8'h82})
            $display("FAIL bp_next got=%b_%h_%h required=1_01_82",
                     instr_valid, instr_pc, instr_opcode);
        else pass_cnt++;
        instr_ready = 1'b1;
    endtask

    task automatic test_jump();
        int cyc = 0;
        int stray = 0;
        do_reset();
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h01; mem[8'h0E] = 8'h81; rom_noi = 8'd22;
        pulse_start();
        repeat (4) @(negedge clk);
        total_cnt++;
        if ({rom_en_data, rom_addr} !== {1'b1, 8'h01})
            $display("FAIL jump_in_read_imm got=%b_%h required=1_01", rom_en_data, rom_addr);
        else pass_cnt++;
        jump_en = 1'b1; jump_addr = 8'h0E;
        @(negedge clk);
        jump_en = 1'b0;
        while (!rom_set_addr && cyc < 10) begin
            if (instr_valid) stray++;
            @(negedge clk);
            cyc++;
        end
        total_cnt++;
        if ({rom_set_addr, rom_addr, stray[7:0]} !== {1'b1, 8'h0E, 8'h00})
            $display("FAIL jump_target got=%b_%h stray=%0d required=1_0e stray=0",
                     rom_set_addr, rom_addr, stray);
        else pass_cnt++;
        cyc = 0;
        while (!instr_valid && cyc < 10) begin @(negedge clk); cyc++; end
        total_cnt++;
        if ({instr_valid, instr_opcode, instr_pc, instr_imm} !== {1'b1, 8'h81, 8'h0E, 8'h00})
            $display("FAIL jump_instr got=%b_%h_%h_%h required=1_81_0e_00",
                     instr_valid, instr_opcode, instr_pc, instr_imm);
        else pass_cnt++;
        @(negedge clk);
        jump_en = 1'b1; jump_addr = 8'h30;
        @(negedge clk);
        jump_en = 1'b0;
        run_scoreboard(10, "jump_oob");
        // Redirect out of HALT resumes fetching at the target.
        push_model(8'h0E);
        jump_en = 1'b1; jump_addr = 8'h0E;
        @(negedge clk);
        jump_en = 1'b0;
        run_scoreboard(100, "jump_from_halt");
    endtask

    task automatic test_truncated();
        int en0, set0, cyc;
        instr_t e;
        do_reset();
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h55; rom_noi = 8'd1;
        e = {8'h20, 8'h00, 8'h00, 1'b1};
        exp_q.push_back(e);
        en0 = en_count;
        pulse_start();
        run_scoreboard(30, "truncated");
        total_cnt++;
        if (en_count - en0 !== 1)
            $display("FAIL truncated_reads got=%0d required=1", en_count - en0);
        else pass_cnt++;
        do_reset();
        rom_noi = 8'd0;
        set0 = set_count;
        pulse_start();
        cyc = 0;
        while (!halted && cyc < 5) begin @(negedge clk); cyc++; end
        total_cnt++;
        if ({halted, 8'(set_count - set0)} !== {1'b1, 8'h00})
            $display("FAIL noi_zero halted=%b sets=%0d required=1 sets=0",
                     halted, set_count - set0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [39:0] outs;
        do_reset();
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h01; mem[2] = 8'h81; rom_noi = 8'd3;
        pulse_start();
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({rom_set_addr, rom_addr} !== {1'b1, 8'h01})
            $display("FAIL reset_mid_set_imm got=%b_%h required=1_01", rom_set_addr, rom_addr);
        else pass_cnt++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        outs = {rom_addr, rom_set_addr, rom_en_data, instr_valid, instr_opcode, instr_imm,
                instr_pc, instr_two_byte, busy, halted};
        total_cnt++;
        if (outs !== '0) $display("FAIL reset_mid_outputs got=%h required=0", outs);
        else pass_cnt++;
        push_model(0);
        pulse_start();
        run_scoreboard(60, "reset_mid_refetch");
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; jump_en = 1'b0; jump_addr = 8'h00;
        instr_ready = 1'b1; rom_noi = 8'd0;
        clear_mem();
        test_reset();
        test_load_imm();
        test_full_program();
        test_backpressure();
        test_jump();
        test_truncated();
        test_reset_mid();
        total_cnt++;
        if (excl_viol !== 0) $display("FAIL strobe_exclusion got=%0d required=0", excl_viol);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
